// File: rtl/nixie_ctrl_pkg.sv
// Shared types and helpers for the nixie high-voltage supply controllers.
package nixie_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SOFTSTART = 2'd1,
    REGULATE  = 2'd2,
    FAULT     = 2'd3
  } reg_state_t;

  function automatic int sat_add(input int base, input int delta, input int lo, input int hi);
    int sum;
    sum = base + delta;
    if (sum < lo) return lo;
    if (sum > hi) return hi;
    return sum;
  endfunction

  function automatic logic is_running(input reg_state_t s);
    return (s == SOFTSTART) || (s == REGULATE);
  endfunction

endpackage

// File: rtl/pwm_regulator_if.sv
// Control/status bundle between the supply sequencer (master) and the PWM regulator (slave).
interface pwm_regulator_if
  import nixie_ctrl_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 10
);
  logic              enable;
  logic [DATA_W-1:0] setpoint;
  logic [DATA_W-1:0] actual;
  logic              adc_ready;
  logic              pwm;
  logic [CNT_W-1:0]  duty;
  reg_state_t        state;
  logic              fault;

  modport master (
    output enable, setpoint, actual, adc_ready,
    input  pwm, duty, state, fault
  );

  modport slave (
    input  enable, setpoint, actual, adc_ready,
    output pwm, duty, state, fault
  );
endinterface

// File: rtl/pwm_period_gen.sv
// PWM period counter: latches a new duty only at period end so pulses are never truncated.
module pwm_period_gen #(
  parameter int PERIOD = 1000,
  parameter int CNT_W  = $clog2(PERIOD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [CNT_W-1:0] duty_next,
  output logic             period_end,
  output logic             pwm,
  output logic [CNT_W-1:0] duty
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;

  // pwm is computed from the next count so that the flop and the counter stay aligned
  always_comb begin
    count_d = '0;
    duty_d  = '0;
    pwm_d   = 1'b0;
    if (run) begin
      if (count_q == LAST) begin
        count_d = '0;
        duty_d  = duty_next;
      end else begin
        count_d = count_q + CNT_W'(1);
        duty_d  = duty_q;
      end
      pwm_d = count_d < duty_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
    end
  end

  // Count is held at 0 while stopped, so this only fires in running states.
  assign period_end = (count_q == LAST);
  assign pwm        = pwm_q;
  assign duty       = duty_q;

endmodule

// File: rtl/pwm_regulator.sv
// Closed-loop boost PWM regulator: soft-start, proportional duty update, sticky over-voltage fault.
module pwm_regulator
  import nixie_ctrl_pkg::*;
#(
  parameter int DATA_W     = 10,
  parameter int PERIOD     = 1000,
  parameter int DUTY_MIN   = 70,
  parameter int DUTY_MAX   = 990,
  parameter int GAIN_SHIFT = 0,
  parameter int RAMP_STEP  = 10,
  parameter int OVP_LIMIT  = 950,
  parameter int CNT_W      = $clog2(PERIOD + 1)
) (
  input logic         clk,
  input logic         rst_n,
  pwm_regulator_if.slave bus
);

  localparam logic [CNT_W-1:0] DMIN = CNT_W'(DUTY_MIN);
  localparam logic [CNT_W-1:0] DMAX = CNT_W'(DUTY_MAX);

  // Reset asserts immediately but is released on a clock edge.
  logic [1:0] rst_sync_q;
  logic       srst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign srst_n = rst_sync_q[1];

  reg_state_t             state_q, state_d;
  logic [CNT_W-1:0]       duty_next_q, duty_next_d;
  logic                   adc_ready_q;
  logic                   sample, ovp, period_end, run;
  logic signed [DATA_W:0] err, step;
  logic                   pwm_w;
  logic [CNT_W-1:0]       duty_w;

  assign sample = bus.adc_ready && !adc_ready_q;
  assign ovp    = sample && (int'(bus.actual) > OVP_LIMIT);
  assign err    = $signed({1'b0, bus.setpoint}) - $signed({1'b0, bus.actual});
  assign step   = err >>> GAIN_SHIFT;

  always_comb begin
    state_d     = state_q;
    duty_next_d = duty_next_q;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d     = SOFTSTART;
          duty_next_d = DMIN;
        end
        SOFTSTART: begin
          if (ovp) begin
            state_d     = FAULT;
            duty_next_d = DMIN;
          end else begin
            if (period_end)
              duty_next_d = CNT_W'(sat_add(int'(duty_next_q), RAMP_STEP, DUTY_MIN, DUTY_MAX));
            if ((sample && (bus.actual >= bus.setpoint)) || (duty_next_d == DMAX))
              state_d = REGULATE;
          end
        end
        REGULATE: begin
          if (ovp) begin
            state_d     = FAULT;
            duty_next_d = DMIN;
          end else if (sample) begin
            duty_next_d = CNT_W'(sat_add(int'(duty_next_q), int'(step), DUTY_MIN, DUTY_MAX));
          end
        end
        FAULT: state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q     <= IDLE;
      duty_next_q <= DMIN;
      adc_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_next_q <= duty_next_d;
      adc_ready_q <= bus.adc_ready;
    end
  end

  // Stopping on the same edge as leaving a running state clears duty_active with the state change.
  assign run = is_running(state_q) && is_running(state_d);

  pwm_period_gen #(
    .PERIOD (PERIOD),
    .CNT_W  (CNT_W)
  ) u_period_gen (
    .clk        (clk),
    .rst_n      (srst_n),
    .run        (run),
    .duty_next  (duty_next_q),
    .period_end (period_end),
    .pwm        (pwm_w),
    .duty       (duty_w)
  );

  assign bus.pwm   = pwm_w;
  assign bus.duty  = duty_w;
  assign bus.state = state_q;
  assign bus.fault = (state_q == FAULT);

endmodule
